// File: rtl/demux_sched_if.sv
// rtl/demux_sched_if.sv - producer and two-consumer handshake bundle for demux_sched
interface demux_sched_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;

  // master: the surrounding producer/consumers; slave: the steering block
  modport master (
    output in_valid, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );
  modport slave (
    input  in_valid, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );
endinterface

// File: rtl/demux_sched.sv
// rtl/demux_sched.sv - single-entry 1-to-2 demux steering controller with saturating beat counters
module demux_sched #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_sched_if.slave     bus,
  input  logic             mode,
  input  logic             cnt_clr,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t       state;
  state_t       state_nxt;
  logic         alive;
  logic         ptr;
  logic         ptr_eff;
  logic         deliver;
  logic         accept;
  logic         sel_nxt;
  logic [W-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    deliver     = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    case (state)
      EMPTY: ;
      FULL: begin
        busy        = 1'b1;
        bus.a_valid = ~sel;
        bus.b_valid = sel;
        bus.a_data  = sel ? '0 : hold;
        bus.b_data  = sel ? hold : '0;
        deliver     = sel ? bus.b_ready : bus.a_ready;
      end
      default: ;
    endcase
    // alive keeps in_ready low until the first edge after reset release
    bus.in_ready = alive & ((state == EMPTY) | deliver);
    accept       = bus.in_valid & bus.in_ready;
    if (accept)       state_nxt = FULL;
    else if (deliver) state_nxt = EMPTY;
  end

  // Target for a newly accepted beat; ptr_eff lets a same-cycle refill see the post-delivery pointer
  always_comb begin
    ptr_eff = ptr ^ deliver;
    sel_nxt = ptr_eff;
    if (mode && bus.a_ready && !bus.b_ready)      sel_nxt = 1'b0;
    else if (mode && bus.b_ready && !bus.a_ready) sel_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      ptr   <= 1'b0;
      sel   <= 1'b0;
      hold  <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      alive <= 1'b1;
      if (deliver) ptr <= ~ptr;
      if (accept) begin
        hold <= bus.in_data;
        sel  <= sel_nxt;
      end
      if (cnt_clr) begin
        cnt_a <= '0;
        cnt_b <= '0;
      end else if (deliver) begin
        if (!sel && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
        if (sel && cnt_b != CNT_MAX)  cnt_b <= cnt_b + 1'b1;
      end
    end
  end

endmodule
